// File: rtl/contour_pkg.sv
// rtl/contour_pkg.sv - shared states, tap indices and border masks for the contour window sequencer
package contour_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    // Row-major 3x3 tap positions; tap 4 is the window centre
    localparam int TAP_NW = 0;
    localparam int TAP_N  = 1;
    localparam int TAP_NE = 2;
    localparam int TAP_W  = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_E  = 5;
    localparam int TAP_SW = 6;
    localparam int TAP_S  = 7;
    localparam int TAP_SE = 8;

    localparam logic [8:0] MASK_TOP   = 9'((1 << TAP_NW) | (1 << TAP_N) | (1 << TAP_NE));
    localparam logic [8:0] MASK_BOT   = 9'((1 << TAP_SW) | (1 << TAP_S) | (1 << TAP_SE));
    localparam logic [8:0] MASK_LEFT  = 9'((1 << TAP_NW) | (1 << TAP_W) | (1 << TAP_SW));
    localparam logic [8:0] MASK_RIGHT = 9'((1 << TAP_NE) | (1 << TAP_E) | (1 << TAP_SE));

    // Returns the set of taps that stay visible for a centre on the given frame edges
    function automatic logic [8:0] keep_mask(input logic top, input logic bot,
                                             input logic left, input logic right);
        logic [8:0] m;
        m = '1;
        if (top)   m = m & ~MASK_TOP;
        if (bot)   m = m & ~MASK_BOT;
        if (left)  m = m & ~MASK_LEFT;
        if (right) m = m & ~MASK_RIGHT;
        m[TAP_C] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/contour_window_sequencer_if.sv
// rtl/contour_window_sequencer_if.sv - pixel-in / window-out bundle of the contour window sequencer
interface contour_window_sequencer_if #(parameter int PIX_W = 10);
    logic               iEnable;
    logic               iValid;
    logic               iSof;
    logic [PIX_W-1:0]   iPixel;
    logic               iClrErr;
    logic               oReady;
    logic               oWinValid;
    logic [9*PIX_W-1:0] oWin;
    logic [9:0]         oX;
    logic [9:0]         oY;
    logic               oBorder;
    logic               oFrameDone;
    logic               oBusy;
    logic               oErr;

    modport master (
        output iEnable, iValid, iSof, iPixel, iClrErr,
        input  oReady, oWinValid, oWin, oX, oY, oBorder, oFrameDone, oBusy, oErr
    );

    modport slave (
        input  iEnable, iValid, iSof, iPixel, iClrErr,
        output oReady, oWinValid, oWin, oX, oY, oBorder, oFrameDone, oBusy, oErr
    );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-clock line RAM with registered read, read-before-write
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int W     = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/contour_window_sequencer.sv
// rtl/contour_window_sequencer.sv - frame FSM, line-buffer chain and masked 3x3 window generation
module contour_window_sequencer
    import contour_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PIX_W    = 10
) (
    input  logic clk,
    input  logic rst,
    contour_window_sequencer_if.slave bus
);
    if (H_ACTIVE < 4 || H_ACTIVE > 1024 || V_ACTIVE < 3 || V_ACTIVE > 1024) begin : g_bad_geometry
        $error("contour_window_sequencer: H_ACTIVE/V_ACTIVE out of range");
    end

    localparam int         AW     = $clog2(H_ACTIVE);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t state, state_nxt;
    logic   ready_r;
    logic [9:0] in_x, in_y, nx, ny;
    logic [3*PIX_W-1:0] c0, c1, col_new;
    logic [PIX_W-1:0] lb1_q, lb2_q, push_pix;
    logic [9*PIX_W-1:0] win_q, win_nxt;
    logic [9:0] x_q, y_q, push_x, next_x;
    logic wv_q, border_q, done_q, err_q;
    logic accept, in_frame, idle_like, sof_start, resync, frame_in, flush_push, push;
    logic at_first_ctr, last_in, emit, last_win, drop;
    logic [8:0] keep;

    assign accept       = ready_r & bus.iValid;
    assign in_frame     = (state == ST_PRIME) || (state == ST_RUN);
    assign idle_like    = (state == ST_IDLE) || (state == ST_WAIT);
    assign sof_start    = accept & idle_like & bus.iSof & bus.iEnable;
    assign resync       = accept & in_frame & bus.iSof;
    assign frame_in     = accept & in_frame;
    assign flush_push   = (state == ST_FLUSH);
    assign push         = sof_start | frame_in | flush_push;
    assign drop         = flush_push & bus.iValid;
    assign push_x       = (sof_start | resync) ? 10'd0 : in_x;
    assign next_x       = (push_x == X_LAST) ? 10'd0 : push_x + 10'd1;
    assign push_pix     = flush_push ? '0 : bus.iPixel;
    assign at_first_ctr = (in_x == 10'd1) && (in_y == 10'd1);
    assign last_in      = (in_x == X_LAST) && (in_y == Y_LAST);
    assign emit         = (frame_in & ~resync & ((state == ST_RUN) | at_first_ctr)) | flush_push;
    assign last_win     = emit & (nx == X_LAST) & (ny == Y_LAST);

    // Column slices: [top] = line y-2, [mid] = line y-1, [bot] = incoming pixel
    assign col_new = {push_pix, lb1_q, lb2_q};

    // Read address runs one pixel ahead so the next column is ready on its accept cycle
    line_buffer #(.DEPTH(H_ACTIVE), .W(PIX_W), .AW(AW)) u_lb1 (
        .clk(clk), .we(push), .waddr(push_x[AW-1:0]), .wdata(push_pix),
        .re(push), .raddr(next_x[AW-1:0]), .rdata(lb1_q)
    );

    line_buffer #(.DEPTH(H_ACTIVE), .W(PIX_W), .AW(AW)) u_lb2 (
        .clk(clk), .we(push), .waddr(push_x[AW-1:0]), .wdata(lb1_q),
        .re(push), .raddr(next_x[AW-1:0]), .rdata(lb2_q)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (sof_start) state_nxt = ST_PRIME;
            ST_WAIT: begin
                if (sof_start)         state_nxt = ST_PRIME;
                else if (!bus.iEnable) state_nxt = ST_IDLE;
            end
            ST_PRIME: if (frame_in && !resync && at_first_ctr) state_nxt = ST_RUN;
            ST_RUN: begin
                if (resync)                   state_nxt = ST_PRIME;
                else if (frame_in && last_in) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: if (last_win) state_nxt = bus.iEnable ? ST_WAIT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        logic [3*PIX_W-1:0] src;
        win_nxt = '0;
        src     = '0;
        keep    = keep_mask(ny == 10'd0, ny == Y_LAST, nx == 10'd0, nx == X_LAST);
        for (int i = 0; i < 9; i++) begin
            src = (i % 3 == 0) ? c0 : ((i % 3 == 1) ? c1 : col_new);
            win_nxt[i*PIX_W +: PIX_W] = keep[i] ? src[(i/3)*PIX_W +: PIX_W] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready_r  <= 1'b0;
            in_x     <= '0;
            in_y     <= '0;
            nx       <= '0;
            ny       <= '0;
            c0       <= '0;
            c1       <= '0;
            win_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            wv_q     <= 1'b0;
            border_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_r <= (state_nxt != ST_FLUSH);
            wv_q    <= emit;
            done_q  <= last_win;

            if (push) in_x <= next_x;
            if (sof_start | resync)             in_y <= '0;
            else if (frame_in && in_x == X_LAST) in_y <= in_y + 10'd1;

            if (push) begin
                c0 <= c1;
                c1 <= col_new;
            end

            if (sof_start | resync) begin
                nx <= '0;
                ny <= '0;
            end else if (emit) begin
                nx <= (nx == X_LAST) ? 10'd0 : nx + 10'd1;
                if (nx == X_LAST) ny <= (ny == Y_LAST) ? 10'd0 : ny + 10'd1;
            end

            if (emit) begin
                win_q    <= win_nxt;
                x_q      <= nx;
                y_q      <= ny;
                border_q <= (nx == 10'd0) | (nx == X_LAST) | (ny == 10'd0) | (ny == Y_LAST);
            end

            // An error event in the same cycle as the clear leaves the flag set
            if (resync | drop)    err_q <= 1'b1;
            else if (bus.iClrErr) err_q <= 1'b0;
        end
    end

    assign bus.oReady     = ready_r;
    assign bus.oWinValid  = wv_q;
    assign bus.oWin       = win_q;
    assign bus.oX         = x_q;
    assign bus.oY         = y_q;
    assign bus.oBorder    = border_q;
    assign bus.oFrameDone = done_q;
    assign bus.oBusy      = (state != ST_IDLE);
    assign bus.oErr       = err_q;
endmodule

// File: tb/tb_contour_window_sequencer.sv
// tb/tb_contour_window_sequencer.sv - directed, table-driven bench for contour_window_sequencer
module tb_contour_window_sequencer;
    localparam int H = 8;
    localparam int V = 4;
    localparam int P = 10;

    typedef int taps_t [9];
    typedef struct {
        int    cx;
        int    cy;
        bit    b;
        taps_t t;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    contour_window_sequencer_if #(.PIX_W(P)) bus();

    contour_window_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(P)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int passed = 0;
    int total  = 0;

    logic [9*P-1:0] cap_win [128];
    int             cap_x   [128];
    int             cap_y   [128];
    bit             cap_b   [128];
    logic [9*P-1:0] ref_win [32];
    int cap_n = 0, done_n = 0, done_x = 0, done_y = 0, done_at = 0, low_n = 0;

    vec_t vecs [8];
    int   nvec = 0;

    always @(negedge clk) begin
        if (bus.oWinValid) begin
            if (cap_n < 128) begin
                cap_win[cap_n] = bus.oWin;
                cap_x[cap_n]   = int'(bus.oX);
                cap_y[cap_n]   = int'(bus.oY);
                cap_b[cap_n]   = bus.oBorder;
            end
            cap_n++;
        end
        if (bus.oFrameDone) begin
            done_n++;
            done_x  = int'(bus.oX);
            done_y  = int'(bus.oY);
            done_at = cap_n;
        end
        if (!bus.oReady && !rst) low_n++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add_vec(input int cx, input int cy, input bit b, input taps_t t);
        vecs[nvec].cx = cx;
        vecs[nvec].cy = cy;
        vecs[nvec].b  = b;
        vecs[nvec].t  = t;
        nvec++;
    endtask

    task automatic clear_caps();
        cap_n  = 0;
        done_n = 0;
        low_n  = 0;
    endtask

    task automatic send(input int pix, input bit sof, input bit gaps);
        int g;
        int waited;
        g = 0;
        while (gaps && $urandom_range(1, 0) == 1 && g < 8) begin
            @(negedge clk);
            bus.iValid = 1'b0;
            g++;
        end
        @(negedge clk);
        bus.iValid = 1'b1;
        bus.iSof   = sof;
        bus.iPixel = P'(pix);
        waited = 0;
        while (!bus.oReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.oReady) begin
            total++;
            $display("FAIL send_ready: oReady stayed %0b for pixel %0d, expected 1", bus.oReady, pix);
        end
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        bus.iValid = 1'b0;
        bus.iSof   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sof, input bit gaps);
        for (int n = 0; n < H * V; n++) send(n, sof && n == 0, gaps);
        go_idle(20);
    endtask

    function automatic int diff_vs_ref(input int base);
        int bad = 0;
        for (int i = 0; i < H * V; i++) begin
            if (cap_win[base + i] !== ref_win[i] || cap_x[base + i] != i % H || cap_y[base + i] != i / H)
                bad++;
        end
        return bad;
    endfunction

    initial begin
        logic [9*P-1:0] exp_w;
        int bad;
        int idx;

        rst = 1'b1;
        bus.iEnable = 1'b1;
        bus.iValid  = 1'b0;
        bus.iSof    = 1'b0;
        bus.iPixel  = '0;
        bus.iClrErr = 1'b0;

        add_vec(3, 1, 1'b0, '{2, 3, 4, 10, 11, 12, 18, 19, 20});
        add_vec(0, 0, 1'b1, '{0, 0, 0, 0, 0, 1, 0, 8, 9});
        add_vec(7, 3, 1'b1, '{22, 23, 0, 30, 31, 0, 0, 0, 0});
        add_vec(1, 1, 1'b0, '{0, 1, 2, 8, 9, 10, 16, 17, 18});
        add_vec(7, 0, 1'b1, '{0, 0, 0, 6, 7, 0, 14, 15, 0});
        add_vec(0, 3, 1'b1, '{0, 16, 17, 0, 24, 25, 0, 0, 0});
        add_vec(4, 2, 1'b0, '{11, 12, 13, 19, 20, 21, 27, 28, 29});
        add_vec(0, 1, 1'b1, '{0, 0, 1, 0, 8, 9, 0, 16, 17});

        #2;
        chk("reset_outputs", {bus.oWinValid, bus.oFrameDone, bus.oBusy, bus.oErr, bus.oReady, bus.oX, bus.oY}, 96'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", bus.oReady, 1);
        chk("idle_busy", bus.oBusy, 0);

        clear_caps();
        for (int n = 0; n < 3; n++) send(5, 1'b0, 1'b0);
        go_idle(4);
        chk("idle_discard_busy", bus.oBusy, 0);
        chk("idle_discard_windows", cap_n, 0);

        // Gapless ramp frame
        clear_caps();
        send_frame(1'b1, 1'b0);
        chk("ramp_count", cap_n, 32);
        chk("ramp_done_count", done_n, 1);
        chk("ramp_done_xy", {done_x[15:0], done_y[15:0]}, {16'd7, 16'd3});
        chk("ramp_done_last", done_at, 32);
        chk("ramp_ready_low", low_n, 9);
        chk("ramp_wait_busy", bus.oBusy, 1);
        bad = 0;
        for (int i = 0; i < 32; i++) if (cap_x[i] != i % H || cap_y[i] != i / H) bad++;
        chk("ramp_raster_order", bad, 0);
        for (int v = 0; v < nvec; v++) begin
            exp_w = '0;
            for (int j = 0; j < 9; j++) exp_w[j*P +: P] = P'(vecs[v].t[j]);
            idx = vecs[v].cy * H + vecs[v].cx;
            chk($sformatf("win_%0d_%0d", vecs[v].cx, vecs[v].cy), cap_win[idx], exp_w);
            chk($sformatf("border_%0d_%0d", vecs[v].cx, vecs[v].cy), cap_b[idx], vecs[v].b);
        end
        for (int i = 0; i < 32; i++) ref_win[i] = cap_win[i];

        // Same frame with random input gaps
        clear_caps();
        send_frame(1'b1, 1'b1);
        chk("gap_count", cap_n, 32);
        chk("gap_done_count", done_n, 1);
        chk("gap_vs_gapless", diff_vs_ref(0), 0);

        // Resync: fresh iSof at pixel index 13
        clear_caps();
        for (int n = 0; n < 13; n++) send(n, n == 0, 1'b0);
        for (int n = 0; n < H * V; n++) send(n, n == 0, 1'b0);
        go_idle(20);
        chk("resync_err", bus.oErr, 1);
        chk("resync_count", cap_n, 36);
        chk("resync_old_last_x", cap_x[3], 3);
        chk("resync_new_frame", diff_vs_ref(4), 0);
        @(negedge clk);
        bus.iClrErr = 1'b1;
        @(negedge clk);
        bus.iClrErr = 1'b0;
        @(negedge clk);
        chk("clr_err", bus.oErr, 0);

        // iEnable dropped mid-RUN, iValid held through FLUSH
        clear_caps();
        for (int n = 0; n < 20; n++) send(n, n == 0, 1'b0);
        bus.iEnable = 1'b0;
        for (int n = 20; n < H * V; n++) send(n, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        go_idle(5);
        chk("flush_drop_err", bus.oErr, 1);
        chk("flush_drop_count", cap_n, 32);
        chk("flush_drop_content", diff_vs_ref(0), 0);
        chk("disable_idle_busy", bus.oBusy, 0);

        // Asynchronous reset mid-RUN
        bus.iEnable = 1'b1;
        clear_caps();
        for (int n = 0; n < 20; n++) send(n, n == 0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_flags", {bus.oWinValid, bus.oFrameDone, bus.oBusy, bus.oErr, bus.oBorder, bus.oReady}, 0);
        chk("rst_mid_xy", {bus.oX, bus.oY}, 0);
        chk("rst_mid_win", bus.oWin, 0);
        @(negedge clk);
        bus.iValid = 1'b0;
        rst = 1'b0;
        clear_caps();
        send_frame(1'b0, 1'b0);
        chk("no_sof_windows", cap_n, 0);
        chk("no_sof_busy", bus.oBusy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
